// File: rtl/cdb_broadcast_arbiter.sv
// Result broadcast arbiter: one holding register per producer, round-robin pick of one
// held result per cycle, registered broadcast, and branch-flush kill of younger results.
module cdb_broadcast_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int MAP_W   = 6,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int NUM_W   = 32
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_wr,
  input  logic [NUM_REQ*MAP_W-1:0]    req_map,
  input  logic [NUM_REQ*REG_W-1:0]    req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]   req_val,
  input  logic [NUM_REQ*NUM_W-1:0]    req_instr_num,
  input  logic                        flush,
  input  logic [NUM_W-1:0]            flush_instr_num,
  output logic                        broadcast_flag,
  output logic [MAP_W-1:0]            broadcast_map,
  output logic [REG_W-1:0]            broadcast_reg,
  output logic [DATA_W-1:0]           broadcast_val,
  output logic [NUM_W-1:0]            exe_instr_num,
  output logic                        complete_flag_rob,
  output logic [15:0]                 conflict_cnt
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: producer i transfers on a cycle where req_valid[i] && req_ready[i];
  // ready never depends on valid, and a flushed-young request is still consumed.
  logic [NUM_REQ-1:0] hold_v_q, hold_v_d;
  logic [NUM_REQ-1:0] hold_wr_q;
  logic [MAP_W-1:0]   hold_map_q [NUM_REQ];
  logic [REG_W-1:0]   hold_reg_q [NUM_REQ];
  logic [DATA_W-1:0]  hold_val_q [NUM_REQ];
  logic [NUM_W-1:0]   hold_num_q [NUM_REQ];

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               bc_flag_q, cmp_flag_q;
  logic [MAP_W-1:0]   bc_map_q;
  logic [REG_W-1:0]   bc_reg_q;
  logic [DATA_W-1:0]  bc_val_q;
  logic [NUM_W-1:0]   bc_num_q;

  logic [NUM_REQ-1:0] kill, young_in, elig, grant, accept, load;
  logic [PTR_W-1:0]   win;
  logic               found;

  always_comb begin
    kill     = '0;
    young_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      kill[i]     = flush && hold_v_q[i] && (hold_num_q[i] > flush_instr_num);
      young_in[i] = flush && (req_instr_num[i*NUM_W +: NUM_W] > flush_instr_num);
    end
  end

  // Round-robin search starting at rr_ptr over the entries that survive a flush.
  always_comb begin
    elig  = hold_v_q & ~kill;
    found = 1'b0;
    win   = '0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && elig[i] && (((int'(rr_ptr_q) + k) % NUM_REQ) == i)) begin
          found    = 1'b1;
          win      = PTR_W'(i);
          grant[i] = 1'b1;
        end
      end
    end
  end

  assign req_ready = RESET ? '0 : (~hold_v_q | grant);
  assign accept    = req_valid & req_ready;
  assign load      = accept & ~young_in;
  assign hold_v_d  = (hold_v_q & ~grant & ~kill) | load;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      rr_ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end
    cnt_d = cnt_q;
    if (($countones(hold_v_q) > 1) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_v_q   <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      bc_flag_q  <= 1'b0;
      cmp_flag_q <= 1'b0;
      bc_map_q   <= '0;
      bc_reg_q   <= '0;
      bc_val_q   <= '0;
      bc_num_q   <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (found) begin
        bc_flag_q  <= hold_wr_q[win];
        cmp_flag_q <= (hold_num_q[win] != '0);
        bc_map_q   <= hold_map_q[win];
        bc_reg_q   <= hold_reg_q[win];
        bc_val_q   <= hold_val_q[win];
        bc_num_q   <= hold_num_q[win];
      end else begin
        bc_flag_q  <= 1'b0;
        cmp_flag_q <= 1'b0;
      end
    end
  end

  // Payload needs no reset: it is only observed through hold_v_q.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (load[i]) begin
        hold_wr_q[i]  <= req_wr[i];
        hold_map_q[i] <= req_map[i*MAP_W +: MAP_W];
        hold_reg_q[i] <= req_reg[i*REG_W +: REG_W];
        hold_val_q[i] <= req_val[i*DATA_W +: DATA_W];
        hold_num_q[i] <= req_instr_num[i*NUM_W +: NUM_W];
      end
    end
  end

  assign broadcast_flag    = bc_flag_q;
  assign complete_flag_rob = cmp_flag_q;
  assign broadcast_map     = bc_map_q;
  assign broadcast_reg     = bc_reg_q;
  assign broadcast_val     = bc_val_q;
  assign exe_instr_num     = bc_num_q;
  assign conflict_cnt      = cnt_q;
endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Bench for cdb_broadcast_arbiter: directed scenarios plus random traffic, all checked
// against a queue/array reference model of holding slots and round-robin selection.
module tb_cdb_broadcast_arbiter;
  localparam int N      = 3;
  localparam int MAP_W  = 6;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NUM_W  = 32;
  localparam int VW     = 2 + MAP_W + REG_W + DATA_W + NUM_W + 16;

  logic CLK = 1'b0;
  logic RESET;
  logic [N-1:0]        req_valid, req_ready, req_wr;
  logic [N*MAP_W-1:0]  req_map;
  logic [N*REG_W-1:0]  req_reg;
  logic [N*DATA_W-1:0] req_val;
  logic [N*NUM_W-1:0]  req_instr_num;
  logic                flush;
  logic [NUM_W-1:0]    flush_instr_num;
  logic                broadcast_flag, complete_flag_rob;
  logic [MAP_W-1:0]    broadcast_map;
  logic [REG_W-1:0]    broadcast_reg;
  logic [DATA_W-1:0]   broadcast_val;
  logic [NUM_W-1:0]    exe_instr_num;
  logic [15:0]         conflict_cnt;

  always #5 CLK = ~CLK;

  cdb_broadcast_arbiter #(.NUM_REQ(N), .MAP_W(MAP_W), .REG_W(REG_W), .DATA_W(DATA_W), .NUM_W(NUM_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_map(req_map), .req_reg(req_reg), .req_val(req_val), .req_instr_num(req_instr_num),
    .flush(flush), .flush_instr_num(flush_instr_num),
    .broadcast_flag(broadcast_flag), .broadcast_map(broadcast_map), .broadcast_reg(broadcast_reg),
    .broadcast_val(broadcast_val), .exe_instr_num(exe_instr_num),
    .complete_flag_rob(complete_flag_rob), .conflict_cnt(conflict_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: slot contents, next slot to favour, and the last broadcast.
  bit                m_v   [N];
  bit                m_wr  [N];
  logic [MAP_W-1:0]  m_map [N];
  logic [REG_W-1:0]  m_reg [N];
  logic [DATA_W-1:0] m_val [N];
  logic [NUM_W-1:0]  m_num [N];
  int                m_rr;
  logic              m_bf, m_cf;
  logic [MAP_W-1:0]  m_omap;
  logic [REG_W-1:0]  m_oreg;
  logic [DATA_W-1:0] m_oval;
  logic [NUM_W-1:0]  m_onum;
  logic [15:0]       m_cnt;
  logic [N-1:0]      exp_ready, obs_ready;
  logic [NUM_W-1:0]  exp_q[$];

  logic [VW-1:0] dut_vec;
  assign dut_vec = {broadcast_flag, complete_flag_rob, broadcast_map, broadcast_reg,
                    broadcast_val, exe_instr_num, conflict_cnt};

  function automatic logic [VW-1:0] exp_vec();
    return {m_bf, m_cf, m_omap, m_oreg, m_oval, m_onum, m_cnt};
  endfunction

  task automatic idle();
    req_valid = '0; req_wr = '0; req_map = '0; req_reg = '0; req_val = '0;
    req_instr_num = '0; flush = 1'b0; flush_instr_num = '0;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [MAP_W-1:0] map,
                         input logic [REG_W-1:0] rg, input logic [DATA_W-1:0] val,
                         input logic [NUM_W-1:0] num);
    req_valid[i] = 1'b1;
    req_wr[i] = wr;
    req_map[i*MAP_W +: MAP_W] = map;
    req_reg[i*REG_W +: REG_W] = rg;
    req_val[i*DATA_W +: DATA_W] = val;
    req_instr_num[i*NUM_W +: NUM_W] = num;
  endtask

  // One clock: settle, predict ready and winner, capture ready, clock, advance model.
  task automatic step();
    int win;
    int pop;
    bit kill [N];
    #2;
    win = -1;
    for (int i = 0; i < N; i++) kill[i] = flush && m_v[i] && (m_num[i] > flush_instr_num);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (win < 0 && m_v[j] && !kill[j]) win = j;
    end
    for (int i = 0; i < N; i++) exp_ready[i] = !RESET && (!m_v[i] || (i == win));
    obs_ready = req_ready;
    @(posedge CLK);
    if (RESET) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      m_rr = 0; m_bf = 0; m_cf = 0; m_omap = '0; m_oreg = '0; m_oval = '0; m_onum = '0; m_cnt = '0;
    end else begin
      pop = 0;
      for (int i = 0; i < N; i++) pop += int'(m_v[i]);
      if (pop > 1 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (win >= 0) begin
        m_bf = m_wr[win]; m_cf = (m_num[win] != 0);
        m_omap = m_map[win]; m_oreg = m_reg[win]; m_oval = m_val[win]; m_onum = m_num[win];
        m_rr = (win + 1) % N;
      end else begin
        m_bf = 1'b0; m_cf = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && exp_ready[i] &&
            !(flush && req_instr_num[i*NUM_W +: NUM_W] > flush_instr_num)) begin
          m_v[i] = 1'b1; m_wr[i] = req_wr[i];
          m_map[i] = req_map[i*MAP_W +: MAP_W]; m_reg[i] = req_reg[i*REG_W +: REG_W];
          m_val[i] = req_val[i*DATA_W +: DATA_W]; m_num[i] = req_instr_num[i*NUM_W +: NUM_W];
        end else if (i == win || kill[i]) begin
          m_v[i] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; idle(); step(); step(); RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; idle(); req_valid = 3'b111;
    step();
    total++; if (obs_ready !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b exp %b", obs_ready, 3'b000); end
    total++; if (dut_vec !== '0) begin bad++; $display("FAIL reset_out: got %h exp 0", dut_vec); end
    RESET = 1'b0; idle();
    step();
    total++; if (obs_ready !== 3'b111) begin bad++; $display("FAIL reset_release_ready: got %b exp 111", obs_ready); end
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL reset_release_out: got %h exp %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 6'd9, 5'd3, 32'hDEAD_BEEF, 32'd7);
    step();
    idle();
    total++; if (broadcast_flag !== 1'b0 || complete_flag_rob !== 1'b0) begin
      bad++; $display("FAIL single_no_bypass: got %b%b exp 00", broadcast_flag, complete_flag_rob); end
    step();
    total++; if (dut_vec !== {1'b1, 1'b1, 6'd9, 5'd3, 32'hDEAD_BEEF, 32'd7, 16'd0}) begin
      bad++; $display("FAIL single_bcast: got %h", dut_vec); end
    step();
    total++; if (broadcast_flag !== 1'b0 || complete_flag_rob !== 1'b0) begin
      bad++; $display("FAIL single_flags_drop: got %b%b exp 00", broadcast_flag, complete_flag_rob); end
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL single_model: got %h exp %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_three();
    logic [N-1:0] rdy_tab [4];
    logic [NUM_W-1:0] exp_num;
    rdy_tab[0] = 3'b111; rdy_tab[1] = 3'b001; rdy_tab[2] = 3'b011; rdy_tab[3] = 3'b111;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 6'(i + 1), 5'(i + 1), 32'(1000 + i), 32'(10 + i));
    exp_q.push_back(32'd10); exp_q.push_back(32'd11); exp_q.push_back(32'd12);
    for (int c = 0; c < 4; c++) begin
      step();
      idle();
      total++; if (obs_ready !== rdy_tab[c]) begin bad++; $display("FAIL three_ready%0d: got %b exp %b", c, obs_ready, rdy_tab[c]); end
      if (c > 0) begin
        exp_num = exp_q.pop_front();
        total++; if (broadcast_flag !== 1'b1 || exe_instr_num !== exp_num) begin
          bad++; $display("FAIL three_order%0d: got flag=%b num=%0d exp num=%0d", c, broadcast_flag, exe_instr_num, exp_num); end
      end
    end
    total++; if (conflict_cnt !== 16'd2) begin bad++; $display("FAIL three_conflict: got %0d exp 2", conflict_cnt); end
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL three_model: got %h exp %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_back_to_back();
    int n0, n1, prev_src, src;
    do_reset();
    n0 = 100; n1 = 200; prev_src = -1;
    for (int c = 0; c < 10; c++) begin
      set_req(0, 1'b1, 6'd1, 5'd1, 32'(n0), 32'(n0));
      set_req(1, 1'b1, 6'd2, 5'd2, 32'(n1), 32'(n1));
      step();
      if (obs_ready[0]) n0++;
      if (obs_ready[1]) n1++;
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL b2b_model%0d: got %h exp %h", c, dut_vec, exp_vec()); end
      if (complete_flag_rob === 1'b1) begin
        src = (exe_instr_num >= 200) ? 1 : 0;
        if (prev_src >= 0) begin
          total++; if (src == prev_src) begin bad++; $display("FAIL b2b_alternate%0d: got src %0d twice", c, src); end
        end
        prev_src = src;
      end
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    set_req(0, 1'b1, 6'd1, 5'd1, 32'h19, 32'd19);
    set_req(1, 1'b1, 6'd2, 5'd2, 32'h21, 32'd21);
    set_req(2, 1'b1, 6'd3, 5'd3, 32'h25, 32'd25);
    step();
    idle();
    flush = 1'b1; flush_instr_num = 32'd20;
    set_req(0, 1'b1, 6'd4, 5'd4, 32'h22, 32'd22);
    step();
    idle();
    total++; if (obs_ready !== 3'b001) begin bad++; $display("FAIL flush_ready: got %b exp 001", obs_ready); end
    total++; if (broadcast_flag !== 1'b1 || exe_instr_num !== 32'd19) begin
      bad++; $display("FAIL flush_survivor: got flag=%b num=%0d exp num=19", broadcast_flag, exe_instr_num); end
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (complete_flag_rob !== 1'b0 || broadcast_flag !== 1'b0) begin
        bad++; $display("FAIL flush_killed%0d: got num=%0d flags=%b%b exp none", c, exe_instr_num, broadcast_flag, complete_flag_rob); end
      total++; if (obs_ready !== 3'b111) begin bad++; $display("FAIL flush_slots_empty%0d: got %b exp 111", c, obs_ready); end
    end
  endtask

  task automatic test_store_bubble();
    do_reset();
    set_req(0, 1'b0, 6'd5, 5'd5, 32'h55, 32'd5);
    set_req(2, 1'b0, 6'd6, 5'd6, 32'h66, 32'd0);
    step();
    idle();
    step();
    total++; if ({broadcast_flag, complete_flag_rob} !== 2'b01 || exe_instr_num !== 32'd5) begin
      bad++; $display("FAIL store_flags: got %b%b num=%0d exp 01 num=5", broadcast_flag, complete_flag_rob, exe_instr_num); end
    step();
    total++; if ({broadcast_flag, complete_flag_rob} !== 2'b00) begin
      bad++; $display("FAIL bubble_flags: got %b%b exp 00", broadcast_flag, complete_flag_rob); end
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL bubble_model: got %h exp %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 6'd1, 5'd1, 32'h1, 32'd31);
    set_req(1, 1'b1, 6'd2, 5'd2, 32'h2, 32'd32);
    step();
    idle();
    RESET = 1'b1;
    step();
    total++; if (dut_vec !== '0) begin bad++; $display("FAIL midreset_out: got %h exp 0", dut_vec); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL midreset_ready: got %b exp 000", req_ready); end
    RESET = 1'b0;
    step();
    total++; if (obs_ready !== 3'b111) begin bad++; $display("FAIL midreset_release_ready: got %b exp 111", obs_ready); end
    total++; if (dut_vec !== '0) begin bad++; $display("FAIL midreset_no_pulse: got %h exp 0", dut_vec); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle();
      RESET = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) != 0)
          set_req(i, 1'($urandom_range(0, 1)), 6'($urandom), 5'($urandom), $urandom, 32'($urandom_range(0, 40)));
      end
      if ($urandom_range(0, 7) == 0) begin
        flush = 1'b1; flush_instr_num = 32'($urandom_range(0, 40));
      end
      step();
      total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rand_ready%0d: got %b exp %b", c, obs_ready, exp_ready); end
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rand_out%0d: got %h exp %h", c, dut_vec, exp_vec()); end
    end
    RESET = 1'b0;
    idle();
  endtask

  initial begin
    RESET = 1'b0;
    idle();
    m_rr = 0; m_cnt = '0;
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    test_reset();
    test_single();
    test_three();
    test_back_to_back();
    test_flush();
    test_store_bubble();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
